// File: rtl/fpnew_pkg.sv
// Shared FPU types plus result-buffer sizing helpers.
// The result buffer's optional sticky flags are enabled by FPNEW_RESULT_BUF_STICKY_EN.
package fpnew_pkg;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  localparam int unsigned RESULT_BUF_MIN_DEPTH = 2;

  function automatic int unsigned result_buf_cnt_width(
    input int unsigned depth
  );
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fpnew_result_buf_mem.sv
// Register array for the opgroup result buffer.
// One write port and one asynchronous read port; storage is not reset.
module fpnew_result_buf_mem #(
  parameter type         entry_t = logic,
  parameter int unsigned Depth   = 4,
  localparam int unsigned AW     = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  entry_t        wdata_i,
  input  logic [AW-1:0] raddr_i,
  output entry_t        rdata_o
);

  entry_t mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fpnew_opgroup_result_buffer.sv
// In-order decoupling FIFO between an opgroup block and the FPU output arbiter.
// Define FPNEW_RESULT_BUF_STICKY_EN to add sticky status accumulation ports.
module fpnew_opgroup_result_buffer
  import fpnew_pkg::*;
#(
  parameter int unsigned Width   = 32,
  parameter int unsigned Depth   = 4,
  parameter type         TagType = logic,
  localparam int unsigned CW     = result_buf_cnt_width(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] result_i,
  input  status_t          status_i,
  input  logic             ext_bit_i,
  input  TagType           tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] result_o,
  output status_t          status_o,
  output logic             ext_bit_o,
  output TagType           tag_o,
  output logic [CW-1:0]    fill_o,
  output logic             busy_o
`ifdef FPNEW_RESULT_BUF_STICKY_EN
  ,
  input  logic             sticky_clr_i,
  output status_t          sticky_status_o
`endif
);

  localparam int unsigned AW = $clog2(Depth);

  if (Depth < RESULT_BUF_MIN_DEPTH || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("Depth must be a power of two and at least RESULT_BUF_MIN_DEPTH");
  end

  typedef struct packed {
    logic [Width-1:0] result;
    status_t          status;
    logic             ext_bit;
    TagType           tag;
  } entry_t;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] fill_q, fill_d;
  logic          busy_q;
  logic          push, pop;
  entry_t        wdata, rdata;

  assign in_ready_o  = (fill_q != CW'(Depth));
  assign out_valid_o = busy_q;
  assign busy_o      = busy_q;
  assign fill_o      = fill_q;

  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fill_d = fill_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (push && !pop) begin
      fill_d = fill_q + CW'(1);
    end else if (pop && !push) begin
      fill_d = fill_q - CW'(1);
    end
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      fill_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
      busy_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fill_q <= fill_d;
      busy_q <= (fill_d != '0);
    end
  end

  assign wdata = '{
    result:  result_i,
    status:  status_i,
    ext_bit: ext_bit_i,
    tag:     tag_i
  };

  fpnew_result_buf_mem #(
    .entry_t (entry_t),
    .Depth   (Depth)
  ) i_mem (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (wdata),
    .raddr_i (rptr_q),
    .rdata_o (rdata)
  );

  assign result_o  = rdata.result;
  assign status_o  = rdata.status;
  assign ext_bit_o = rdata.ext_bit;
  assign tag_o     = rdata.tag;

`ifdef FPNEW_RESULT_BUF_STICKY_EN
  status_t sticky_q, sticky_d;
  status_t pop_flags;

  assign pop_flags = pop ? status_o : '0;

  // A clear coinciding with a pop keeps only that pop's flags.
  always_comb begin
    sticky_d = sticky_q | pop_flags;
    if (sticky_clr_i) sticky_d = pop_flags;
    if (flush_i)      sticky_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_status_o = sticky_q;
`endif

endmodule

// File: tb/tb_fpnew_opgroup_result_buffer.sv
// Directed table-driven bench for fpnew_opgroup_result_buffer (Depth 4).
// Sticky checks are compiled in when FPNEW_RESULT_BUF_STICKY_EN is defined.
module tb_fpnew_opgroup_result_buffer;
  import fpnew_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned D = 4;
  typedef logic [3:0] tag_t;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  result_i, result_o;
  status_t       status_i, status_o;
  logic          ext_i, ext_o;
  tag_t          tag_i, tag_o;
  logic [2:0]    fill;
  logic          busy;
`ifdef FPNEW_RESULT_BUF_STICKY_EN
  logic          sticky_clr;
  status_t       sticky;
`endif

  always #5 clk = ~clk;

  fpnew_opgroup_result_buffer #(
    .Width   (W),
    .Depth   (D),
    .TagType (tag_t)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .result_i    (result_i),
    .status_i    (status_i),
    .ext_bit_i   (ext_i),
    .tag_i       (tag_i),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result_o),
    .status_o    (status_o),
    .ext_bit_o   (ext_o),
    .tag_o       (tag_o),
    .fill_o      (fill),
    .busy_o      (busy)
`ifdef FPNEW_RESULT_BUF_STICKY_EN
    ,
    .sticky_clr_i    (sticky_clr),
    .sticky_status_o (sticky)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs for one cycle and the state expected just after that edge.
  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic        ordy;
    tag_t        tag;
    logic [31:0] res;
    logic        e_valid;
    logic        e_ready;
    logic [2:0]  e_fill;
    tag_t        e_tag;
    logic [31:0] e_res;
  } vec_t;

  vec_t v [22];

  function automatic vec_t mk(logic r, logic f, logic iv, logic ordy,
                              tag_t t, logic [31:0] res, logic ev,
                              logic er, logic [2:0] ef, tag_t et,
                              logic [31:0] eres);
    vec_t x;
    x.rst = r; x.flush = f; x.iv = iv; x.ordy = ordy;
    x.tag = t; x.res = res;
    x.e_valid = ev; x.e_ready = er; x.e_fill = ef;
    x.e_tag = et; x.e_res = eres;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; in_valid = 0; out_ready = 0;
    result_i = '0; status_i = '0; ext_i = 0; tag_i = '0;
`ifdef FPNEW_RESULT_BUF_STICKY_EN
    sticky_clr = 0;
`endif
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    //      rst flush iv ordy tag res           val rdy fill etag eres
    v[0]  = mk(1, 0, 0, 0, 0,  32'h0,        0, 1, 0, 0,  32'h0);
    v[1]  = mk(0, 0, 1, 1, 5,  32'h3F800000, 1, 1, 1, 5,  32'h3F800000);
    v[2]  = mk(0, 0, 0, 1, 0,  32'h0,        0, 1, 0, 0,  32'h0);
    v[3]  = mk(0, 0, 1, 0, 1,  32'hC0DE0001, 1, 1, 1, 1,  32'hC0DE0001);
    v[4]  = mk(0, 0, 1, 0, 2,  32'hC0DE0002, 1, 1, 2, 1,  32'hC0DE0001);
    v[5]  = mk(0, 0, 1, 0, 3,  32'hC0DE0003, 1, 1, 3, 1,  32'hC0DE0001);
    v[6]  = mk(0, 0, 1, 0, 4,  32'hC0DE0004, 1, 0, 4, 1,  32'hC0DE0001);
    v[7]  = mk(0, 0, 1, 0, 5,  32'hC0DE0005, 1, 0, 4, 1,  32'hC0DE0001);
    v[8]  = mk(0, 0, 1, 1, 5,  32'hC0DE0005, 1, 1, 3, 2,  32'hC0DE0002);
    v[9]  = mk(0, 0, 1, 1, 5,  32'hC0DE0005, 1, 1, 3, 3,  32'hC0DE0003);
    v[10] = mk(0, 0, 0, 1, 0,  32'h0,        1, 1, 2, 4,  32'hC0DE0004);
    v[11] = mk(0, 0, 0, 1, 0,  32'h0,        1, 1, 1, 5,  32'hC0DE0005);
    v[12] = mk(0, 0, 0, 1, 0,  32'h0,        0, 1, 0, 0,  32'h0);
    v[13] = mk(0, 0, 1, 0, 6,  32'hC0DE0006, 1, 1, 1, 6,  32'hC0DE0006);
    v[14] = mk(0, 0, 1, 0, 7,  32'hC0DE0007, 1, 1, 2, 6,  32'hC0DE0006);
    v[15] = mk(0, 0, 1, 0, 8,  32'hC0DE0008, 1, 1, 3, 6,  32'hC0DE0006);
    v[16] = mk(0, 1, 1, 1, 9,  32'hC0DE0009, 0, 1, 0, 0,  32'h0);
    v[17] = mk(0, 0, 0, 1, 0,  32'h0,        0, 1, 0, 0,  32'h0);
    v[18] = mk(0, 0, 1, 0, 10, 32'hC0DE000A, 1, 1, 1, 10, 32'hC0DE000A);
    v[19] = mk(0, 0, 1, 0, 11, 32'hC0DE000B, 1, 1, 2, 10, 32'hC0DE000A);
    v[20] = mk(1, 0, 0, 0, 0,  32'h0,        0, 1, 0, 0,  32'h0);
    v[21] = mk(0, 0, 1, 0, 12, 32'hC0DE000C, 1, 1, 1, 12, 32'hC0DE000C);

    tick();
    tick();

    for (int i = 0; i < 22; i++) begin
      string s;
      s = $sformatf("vec%0d", i);
      rst       = v[i].rst;
      flush     = v[i].flush;
      in_valid  = v[i].iv;
      out_ready = v[i].ordy;
      tag_i     = v[i].tag;
      result_i  = v[i].res;
      status_i  = status_t'(5'(v[i].tag));
      ext_i     = v[i].tag[0];
      tick();
      chk({s, ".valid"}, 32'(out_valid), 32'(v[i].e_valid));
      chk({s, ".ready"}, 32'(in_ready), 32'(v[i].e_ready));
      chk({s, ".fill"},  32'(fill), 32'(v[i].e_fill));
      chk({s, ".busy"},  32'(busy), 32'(v[i].e_fill != 0));
      if (v[i].e_valid) begin
        chk({s, ".tag"},    32'(tag_o), 32'(v[i].e_tag));
        chk({s, ".result"}, result_o, v[i].e_res);
        chk({s, ".status"}, 32'(status_o), 32'(5'(v[i].e_tag)));
        chk({s, ".ext"},    32'(ext_o), 32'(v[i].e_tag[0]));
      end
    end

    // Fill to 4 (tag 12 already held), then show in_ready ignores out_ready.
    idle_inputs();
    in_valid = 1;
    for (int t = 13; t < 16; t++) begin
      tag_i = tag_t'(t);
      tick();
    end
    in_valid = 0;
    chk("full.fill", 32'(fill), 32'd4);
    out_ready = 1;
    in_valid  = 1;
    #1;
    chk("full.ready_nocomb", 32'(in_ready), 32'd0);
    chk("full.head_hold", 32'(tag_o), 32'd12);
    tick();
    chk("full.pop_fill", 32'(fill), 32'd3);
    chk("full.pop_head", 32'(tag_o), 32'd13);

    // Stall: head must hold for several cycles.
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall.valid", 32'(out_valid), 32'd1);
      chk("stall.tag", 32'(tag_o), 32'd13);
    end

`ifdef FPNEW_RESULT_BUF_STICKY_EN
    rst = 1;
    tick();
    rst = 0;
    chk("sticky.reset", 32'(sticky), 32'd0);
    in_valid = 1;
    status_i = status_t'(5'b00001);
    tick();
    status_i = status_t'(5'b10000);
    tick();
    in_valid  = 0;
    out_ready = 1;
    tick();
    chk("sticky.pop1", 32'(sticky), 32'b00001);
    tick();
    chk("sticky.pop2", 32'(sticky), 32'b10001);
    out_ready = 0;
    in_valid  = 1;
    status_i  = status_t'(5'b00100);
    tick();
    in_valid   = 0;
    out_ready  = 1;
    sticky_clr = 1;
    tick();
    sticky_clr = 0;
    out_ready  = 0;
    chk("sticky.clr_pop", 32'(sticky), 32'b00100);
    flush = 1;
    tick();
    flush = 0;
    chk("sticky.flush", 32'(sticky), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
